// File: rtl/avst_word_collector.sv
// Collects MSB-first Avalon-ST byte packets into 32-bit words and flags packets not 4 bytes long.
// Keeps a wrapping packet counter and a saturating error counter for debug.
module avst_word_collector #(
  parameter int unsigned PKT_CNT_W = 16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           data_in,
  input  logic                 end_in,
  input  logic                 valid_in,
  output logic                 ready_in,
  output logic [31:0]          data_out,
  output logic [2:0]           len_out,
  output logic                 err_out,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [PKT_CNT_W-1:0] pkt_count,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic {StCollect, StHold} state_e;

  state_e               state_q, state_d;
  logic                 ready_in_q, ready_in_d;
  logic                 valid_out_q, valid_out_d;
  logic [31:0]          data_out_q, data_out_d;
  logic [2:0]           len_out_q, len_out_d;
  logic                 err_out_q, err_out_d;
  logic [31:0]          acc_q, acc_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic       byte_acc;
  logic [2:0] cnt_sat;

  // ready_in_q is high only in StCollect, so it also qualifies the byte handshake.
  assign byte_acc = valid_in && ready_in_q;
  assign cnt_sat  = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    ready_in_d  = ready_in_q;
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    len_out_d   = len_out_q;
    err_out_d   = err_out_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;

    unique case (state_q)
      StCollect: begin
        if (byte_acc) begin
          if (end_in) begin
            data_out_d  = {acc_q[23:0], data_in};
            len_out_d   = cnt_sat;
            err_out_d   = (cnt_sat != 3'd4);
            valid_out_d = 1'b1;
            ready_in_d  = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = StHold;
          end else begin
            acc_d = {acc_q[23:0], data_in};
            cnt_d = cnt_sat;
          end
        end
      end
      StHold: begin
        if (valid_out_q && ready_out) begin
          valid_out_d = 1'b0;
          ready_in_d  = 1'b1;
          pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
          if (err_out_q && (err_count_q != {ERR_CNT_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
          end
          state_d = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StCollect;
      ready_in_q  <= 1'b1;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      len_out_q   <= '0;
      err_out_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      pkt_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_in_q  <= ready_in_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      len_out_q   <= len_out_d;
      err_out_q   <= err_out_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign ready_in  = ready_in_q;
  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign len_out   = len_out_q;
  assign err_out   = err_out_q;
  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_avst_word_collector.sv
// Directed bench for avst_word_collector; a second instance with a 4-bit packet counter
// shares the stimulus to exercise counter wrap.
module tb_avst_word_collector;

  logic        clk;
  logic        reset;
  logic [7:0]  data_in;
  logic        end_in;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] data_out;
  logic [2:0]  len_out;
  logic        err_out;
  logic        valid_out;
  logic        ready_out;
  logic [15:0] pkt_count;
  logic [7:0]  err_count;

  logic        s_ready_in;
  logic [31:0] s_data_out;
  logic [2:0]  s_len_out;
  logic        s_err_out;
  logic        s_valid_out;
  logic [3:0]  s_pkt_count;
  logic [7:0]  s_err_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] pkt_buf [16];

  avst_word_collector #(.PKT_CNT_W(16), .ERR_CNT_W(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .end_in    (end_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .len_out   (len_out),
    .err_out   (err_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .pkt_count (pkt_count),
    .err_count (err_count)
  );

  avst_word_collector #(.PKT_CNT_W(4), .ERR_CNT_W(8)) u_dut_small (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .end_in    (end_in),
    .valid_in  (valid_in),
    .ready_in  (s_ready_in),
    .data_out  (s_data_out),
    .len_out   (s_len_out),
    .err_out   (s_err_out),
    .valid_out (s_valid_out),
    .ready_out (ready_out),
    .pkt_count (s_pkt_count),
    .err_count (s_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends pkt_buf[0..n-1], end_in on the last byte, with `gap` idle cycles after each byte.
  task automatic send_pkt(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int waited = 0;
      data_in  = pkt_buf[i];
      end_in   = (i == n - 1);
      valid_in = 1'b1;
      while (!ready_in && waited < 100) begin
        step();
        waited++;
      end
      if (waited >= 100) check_eq("ready_in_timeout", 32'(ready_in), 32'd1);
      step();
      valid_in = 1'b0;
      end_in   = 1'b0;
      if (i != n - 1) check_eq("no_early_valid", 32'(valid_out), 32'd0);
      for (int g = 0; g < gap; g++) begin
        step();
        if (i != n - 1) check_eq("gap_no_valid", 32'(valid_out), 32'd0);
      end
    end
  endtask

  task automatic handoff();
    ready_out = 1'b1;
    step();
    ready_out = 1'b0;
    check_eq("handoff_valid_out", 32'(valid_out), 32'd0);
    check_eq("handoff_ready_in", 32'(ready_in), 32'd1);
  endtask

  task automatic check_word(input string tag, input logic [31:0] w, input logic [2:0] len,
                            input logic err);
    check_eq({tag, "_valid"}, 32'(valid_out), 32'd1);
    check_eq({tag, "_data"}, data_out, w);
    check_eq({tag, "_len"}, 32'(len_out), 32'(len));
    check_eq({tag, "_err"}, 32'(err_out), 32'(err));
    check_eq({tag, "_ready_in"}, 32'(ready_in), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ready_in"}, 32'(ready_in), 32'd1);
    check_eq({tag, "_valid_out"}, 32'(valid_out), 32'd0);
    check_eq({tag, "_data_out"}, data_out, 32'd0);
    check_eq({tag, "_len_out"}, 32'(len_out), 32'd0);
    check_eq({tag, "_err_out"}, 32'(err_out), 32'd0);
    check_eq({tag, "_pkt_count"}, 32'(pkt_count), 32'd0);
    check_eq({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    data_in   = 8'h00;
    end_in    = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_reset_state("reset");

    // Nominal packet with ready_out held high: valid_out lasts one cycle.
    pkt_buf[0] = 8'h00; pkt_buf[1] = 8'h00; pkt_buf[2] = 8'h01; pkt_buf[3] = 8'h2C;
    ready_out = 1'b1;
    send_pkt(4, 0);
    check_word("nominal", 32'h0000012C, 3'd4, 1'b0);
    step();
    ready_out = 1'b0;
    check_eq("nominal_valid_drop", 32'(valid_out), 32'd0);
    check_eq("nominal_pkt_count", 32'(pkt_count), 32'd1);
    check_eq("nominal_err_count", 32'(err_count), 32'd0);

    // Backpressure, with a byte offered during HOLD that must be ignored.
    pkt_buf[0] = 8'hDE; pkt_buf[1] = 8'hAD; pkt_buf[2] = 8'hBE; pkt_buf[3] = 8'hEF;
    send_pkt(4, 0);
    check_word("bp_first", 32'hDEADBEEF, 3'd4, 1'b0);
    data_in  = 8'h55;
    end_in   = 1'b1;
    valid_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_word("bp_hold", 32'hDEADBEEF, 3'd4, 1'b0);
    end
    valid_in = 1'b0;
    end_in   = 1'b0;
    handoff();
    check_eq("bp_pkt_count", 32'(pkt_count), 32'd2);

    // Short packet; residue from the ignored 0x55 would show up in the upper byte.
    pkt_buf[0] = 8'hAB;
    send_pkt(1, 0);
    check_word("short", 32'h000000AB, 3'd1, 1'b1);
    handoff();

    for (int i = 0; i < 9; i++) pkt_buf[i] = 8'(i + 1);
    send_pkt(6, 0);
    check_word("long6", 32'h03040506, 3'd6, 1'b1);
    handoff();
    send_pkt(9, 0);
    check_word("long9", 32'h06070809, 3'd7, 1'b1);
    handoff();
    check_eq("sl_err_count", 32'(err_count), 32'd3);
    check_eq("sl_pkt_count", 32'(pkt_count), 32'd5);

    // Gapped input.
    pkt_buf[0] = 8'h11; pkt_buf[1] = 8'h22; pkt_buf[2] = 8'h33; pkt_buf[3] = 8'h44;
    send_pkt(4, 2);
    check_word("gapped", 32'h11223344, 3'd4, 1'b0);
    handoff();
    check_eq("gapped_pkt_count", 32'(pkt_count), 32'd6);

    // Reset after two bytes of a packet.
    pkt_buf[0] = 8'hAA; pkt_buf[1] = 8'hBB;
    send_pkt(2, 0);
    reset = 1'b1;
    valid_in = 1'b0;
    step();
    reset = 1'b0;
    check_reset_state("rst_mid");
    pkt_buf[0] = 8'h11; pkt_buf[1] = 8'h22; pkt_buf[2] = 8'h33;
    send_pkt(3, 0);
    check_word("post_rst_short", 32'h00112233, 3'd3, 1'b1);
    handoff();
    pkt_buf[0] = 8'hAA; pkt_buf[1] = 8'hBB;
    send_pkt(2, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("rst_mid2");
    pkt_buf[0] = 8'h11; pkt_buf[1] = 8'h22; pkt_buf[2] = 8'h33; pkt_buf[3] = 8'h44;
    send_pkt(4, 0);
    check_word("post_rst", 32'h11223344, 3'd4, 1'b0);

    // Reset during HOLD, coinciding with ready_out: reset wins, no count.
    reset     = 1'b1;
    ready_out = 1'b1;
    step();
    reset     = 1'b0;
    ready_out = 1'b0;
    check_reset_state("rst_hold");

    // Counter limits.
    ready_out  = 1'b1;
    pkt_buf[0] = 8'h5A;
    for (int p = 0; p < 260; p++) begin
      send_pkt(1, 0);
      if (p == 16) begin
        step();
        check_eq("wrap_small_pkt", 32'(s_pkt_count), 32'd1);
        check_eq("wrap_big_pkt", 32'(pkt_count), 32'd17);
        check_eq("err_count_17", 32'(err_count), 32'd17);
      end
    end
    step();
    ready_out = 1'b0;
    check_eq("sat_err_count", 32'(err_count), 32'hFF);
    check_eq("final_pkt_count", 32'(pkt_count), 32'd260);
    check_eq("final_small_pkt", 32'(s_pkt_count), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
